fpu_addsub_pipe: RTL and testbench
==================================

Name: fpu_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point adder/subtractor. Successor to the combinational FP16 add/sub datapath (sort, align, normalise).
- Generalised to arbitrary exponent/fraction widths.
- Adds a valid/ready handshake with backpressure, full IEEE special-value handling (NaN, infinity, signed zero) and an invalid-operation flag.
- Sits between the FPU operand-issue logic and the result writeback arbiter.

Parameters:
- EXPW, 5, exponent field width (bias = 2^(EXPW-1)-1).
- FRACW, 10, stored fraction width. Total word W = 1+EXPW+FRACW.
- QNAN, {1'b0, all-ones EXPW, 1'b1, (FRACW-1)'b0}, canonical quiet NaN produced on NaN results.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  W  operand A, IEEE layout {sign, exp, frac}.
- in_b  in  W  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  rounded result.
- out_flags  out  4  {NV, OF, UF, NX}.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low. On a clock edge with reset_n=0, all stage valid bits clear, out_valid=0, out_result=0, out_flags=0. In-flight operations are discarded with no output.
- Handshake:
  - Global advance enable en = ~out_valid | out_ready. in_ready = en.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - With en=1, every stage shifts one place per cycle. Bubbles propagate as invalid.
  - With en=0, all stages hold. out_result/out_flags stay stable while out_valid & ~out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid with no stall. Throughput 1/cycle. In-order.
- S1 (sort/align):
  - Effective B sign = b.sign ^ in_sub.
  - Swap so the larger {exp,frac} is the large operand. On magnitude equality, A stays large.
  - Subnormals use effective exponent 1 and hidden bit 0.
  - Right-shift the small significand by the exponent difference, keeping 2 extra bits (guard, round) plus an OR-reduced sticky. Shifts >= FRACW+3 leave only sticky.
  - Classify specials here and carry a special-result tag forward.
- S2 (add): same effective sign adds significands (FRACW+4 bits incl. carry); different sign subtracts small from large (never negative).
- S3 (normalise/round):
  - Carry: shift right 1, exp+1, fold shifted bit into sticky.
  - Leading zeros: shift left by min(lzc, exp-1). If exp would reach 0, the result is subnormal (stored exp 0).
  - Round to nearest, ties to even, using guard | round | sticky. Mantissa rounding carry increments the exponent; subnormal-to-normal promotion is allowed.
- Flags:
  - Exponent >= all-ones after rounding -> result = +/-infinity, OF=1, NX=1.
  - NX = any discarded bit nonzero.
  - UF = result is subnormal or zero, and NX=1.
  - NV only from specials.
- Specials (bypass arithmetic, flags as stated):
  - Any NaN operand -> QNAN. NV=1 if any operand is a signalling NaN (frac MSB 0), else NV=0.
  - inf - inf (effective) -> QNAN, NV=1.
  - Otherwise an infinity operand passes with its effective sign.
- Exact zero result:
  - -0 only if both effective operands are -0.
  - +0 otherwise, including exact cancellation x-x.
- in_sub ignored for NaN payload (canonicalised anyway).

Test Plan:
- 0x3C00 + 0x4000, in_sub=0, out_ready=1 -> out_result 0x4200 exactly 3 cycles after accept, flags 0000.
- 0x7BFF + 0x7BFF -> 0x7C00, flags {NV,OF,UF,NX}=0101. Then 0x7C00 - 0x7C00 (in_sub=1) -> 0x7E00, flags 1000.
- 0x3C00 + 0x1000 (1.0 + 2^-11, exact tie) -> 0x3C00, NX=1. Then 0x3C01 + 0x1000 -> 0x3C02, NX=1 (tie to even).
- 0x0001 + 0x0001 -> 0x0002, flags 0000. 0x03FF + 0x0001 -> 0x0400 (subnormal to normal). 0x3C00 - 0x3C00 -> 0x0000. 0x8000 + 0x8000 -> 0x8000.
- Backpressure: issue 5 back-to-back ops, hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0, outputs stable, no loss or duplication. On release, results drain in order, one per cycle.
- reset_n=0 for 1 cycle with 2 ops in flight -> next cycle out_valid=0, out_result=0, out_flags=0. No stale results appear afterwards.
- Parameter sweep EXPW=8, FRACW=23: 0x3F800000 + 0x40000000 -> 0x40400000 after 3 cycles.

Source files
------------

// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined IEEE-style floating-point adder/subtractor with a valid/ready handshake.
// Stages: sort/align + special classification, significand add/sub, normalise/round/pack.
module fpu_addsub_pipe #(
  parameter int unsigned EXPW  = 5,
  parameter int unsigned FRACW = 10,
  parameter logic [EXPW+FRACW:0] QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}}
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXPW+FRACW:0] in_a,
  input  logic [EXPW+FRACW:0] in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXPW+FRACW:0] out_result,
  output logic [3:0]          out_flags
);

  localparam int unsigned W   = 1 + EXPW + FRACW;
  localparam int unsigned SW  = FRACW + 4;  // {hidden, frac, guard, round, sticky}
  localparam int unsigned XW  = FRACW + 3;  // {hidden, frac, guard, round}
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam int unsigned EW  = (EXPW + 2 > LZW) ? EXPW + 2 : LZW;
  localparam logic [EW-1:0]   EXP_MAX  = EW'((64'd1 << EXPW) - 64'd1);
  localparam logic [EXPW-1:0] EXP_ONES = {EXPW{1'b1}};

  logic en;

  // Pipeline state
  logic                s1_valid_q, s2_valid_q, out_valid_q;
  logic                s1_spec_q, s1_spec_nv_q, s1_sign_q, s1_sub_q, s1_zsign_q;
  logic [W-1:0]        s1_spec_res_q;
  logic [EXPW-1:0]     s1_exp_q;
  logic [SW-1:0]       s1_big_q, s1_small_q;
  logic                s2_spec_q, s2_spec_nv_q, s2_sign_q, s2_zsign_q;
  logic [W-1:0]        s2_spec_res_q;
  logic [EXPW-1:0]     s2_exp_q;
  logic [SW:0]         s2_sum_q;
  logic [W-1:0]        out_result_q;
  logic [3:0]          out_flags_q;

  assign en         = ~out_valid_q | out_ready;
  assign in_ready   = en;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // ---------------------------------------------------------------------------------------------
  // Stage 1: classify, sort by magnitude, align the smaller significand
  // ---------------------------------------------------------------------------------------------
  logic             a_sign, b_sign, l_sign, s_sign;
  logic [EXPW-1:0]  a_exp, b_exp, l_exp, s_exp, l_eexp, s_eexp, exp_diff;
  logic [FRACW-1:0] a_frac, b_frac, l_frac, s_frac;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic             swap;
  logic [XW-1:0]    s_ext, s_shifted;
  logic             s_lost;
  logic             spec_d, spec_nv_d;
  logic [W-1:0]     spec_res_d;

  always_comb begin
    a_sign = in_a[W-1];
    a_exp  = in_a[W-2:FRACW];
    a_frac = in_a[FRACW-1:0];
    b_sign = in_b[W-1] ^ in_sub;
    b_exp  = in_b[W-2:FRACW];
    b_frac = in_b[FRACW-1:0];

    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    a_snan = a_nan && !a_frac[FRACW-1];
    b_snan = b_nan && !b_frac[FRACW-1];

    // Ties keep A as the large operand
    swap = in_b[W-2:0] > in_a[W-2:0];
    if (swap) begin
      l_sign = b_sign; l_exp = b_exp; l_frac = b_frac;
      s_sign = a_sign; s_exp = a_exp; s_frac = a_frac;
    end else begin
      l_sign = a_sign; l_exp = a_exp; l_frac = a_frac;
      s_sign = b_sign; s_exp = b_exp; s_frac = b_frac;
    end

    // Subnormals sit at effective exponent 1 with hidden bit 0
    l_eexp   = (l_exp == '0) ? EXPW'(1) : l_exp;
    s_eexp   = (s_exp == '0) ? EXPW'(1) : s_exp;
    exp_diff = l_eexp - s_eexp;

    s_ext     = {(s_exp != '0), s_frac, 2'b00};
    s_shifted = s_ext >> exp_diff;
    s_lost    = |(s_ext & ~({XW{1'b1}} << exp_diff));

    spec_d     = a_nan | b_nan | a_inf | b_inf;
    spec_nv_d  = 1'b0;
    spec_res_d = QNAN;
    if (a_nan || b_nan) begin
      spec_nv_d = a_snan | b_snan;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec_nv_d = 1'b1;
    end else if (a_inf) begin
      spec_res_d = {a_sign, EXP_ONES, {FRACW{1'b0}}};
    end else begin
      spec_res_d = {b_sign, EXP_ONES, {FRACW{1'b0}}};
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      s1_spec_q     <= spec_d;
      s1_spec_nv_q  <= spec_nv_d;
      s1_spec_res_q <= spec_res_d;
      s1_sign_q     <= l_sign;
      s1_sub_q      <= l_sign ^ s_sign;
      // An exact zero is negative only when both effective operands are negative
      s1_zsign_q    <= a_sign & b_sign;
      s1_exp_q      <= l_eexp;
      s1_big_q      <= {(l_exp != '0), l_frac, 3'b000};
      s1_small_q    <= {s_shifted, s_lost};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: significand add or subtract (large - small never goes negative)
  // ---------------------------------------------------------------------------------------------
  logic [SW:0] sum_d;

  always_comb begin
    if (s1_sub_q) sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    else          sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
  end

  always_ff @(posedge clock) begin
    if (en) begin
      s2_spec_q     <= s1_spec_q;
      s2_spec_nv_q  <= s1_spec_nv_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_sign_q     <= s1_sign_q;
      s2_zsign_q    <= s1_zsign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 3: normalise, round to nearest even, pack and flag
  // ---------------------------------------------------------------------------------------------
  function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
    logic [EW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + EW'(1);
      else                 found = 1'b1;
    end
    return n;
  endfunction

  logic [EW-1:0]    exp_in, lz, lim, sh, exp_n, rexp;
  logic [SW-1:0]    norm;
  logic [FRACW+1:0] mant;
  logic [FRACW-1:0] rfrac;
  logic             rnd_up, nx, normal;
  logic [W-1:0]     res_d;
  logic [3:0]       flags_d;

  always_comb begin
    exp_in = EW'(s2_exp_q);
    lz     = lzc(s2_sum_q[SW-1:0]);
    lim    = exp_in - EW'(1);
    sh     = (lz < lim) ? lz : lim;
    if (s2_sum_q[SW]) begin
      norm  = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = exp_in + EW'(1);
    end else begin
      // Left shift stops at exponent 1; anything still unnormalised is subnormal
      norm  = s2_sum_q[SW-1:0] << sh;
      exp_n = exp_in - sh;
    end

    nx     = norm[2] | norm[1] | norm[0];
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant   = {1'b0, norm[SW-1:3]} + (FRACW+2)'(rnd_up);
    if (mant[FRACW+1]) begin
      rexp  = exp_n + EW'(1);
      rfrac = {FRACW{1'b0}};
    end else begin
      rexp  = exp_n;
      rfrac = mant[FRACW-1:0];
    end
    normal = mant[FRACW+1] | mant[FRACW];

    if (s2_spec_q) begin
      res_d   = s2_spec_res_q;
      flags_d = {s2_spec_nv_q, 3'b000};
    end else if (s2_sum_q == '0) begin
      res_d   = {s2_zsign_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (rexp >= EXP_MAX) begin
      res_d   = {s2_sign_q, EXP_ONES, {FRACW{1'b0}}};
      flags_d = 4'b0101;
    end else begin
      res_d   = {s2_sign_q, normal ? rexp[EXPW-1:0] : {EXPW{1'b0}}, rfrac};
      flags_d = {2'b00, ~normal & nx, nx};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_result_q <= res_d;
        out_flags_q  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Scoreboard bench for fpu_addsub_pipe: FP16 directed vectors, backpressure, reset flush,
// plus an FP32 instance for the wide-parameter case.
module tb_fpu_addsub_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_result;
  logic [3:0]  out_flags;

  logic        w_in_valid, w_in_ready, w_in_sub, w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_in_a, w_in_b, w_out_result;
  logic [3:0]  w_out_flags;

  always #5 clock = ~clock;

  fpu_addsub_pipe dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  fpu_addsub_pipe #(.EXPW(8), .FRACW(23)) dut32 (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (w_in_valid),
    .in_ready   (w_in_ready),
    .in_a       (w_in_a),
    .in_b       (w_in_b),
    .in_sub     (w_in_sub),
    .out_valid  (w_out_valid),
    .out_ready  (w_out_ready),
    .out_result (w_out_result),
    .out_flags  (w_out_flags)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int unsigned due;
    bit          chk_lat;
    int          id;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[18];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          chk_lat_mode = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Hold the operands until accepted; the expectation is queued on the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [15:0] er, input logic [3:0] ef, input int id);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        sb_q.push_back('{er, ef, cyc + 3, chk_lat_mode, id});
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout id=%0d: in_ready stayed 0, required 1", id);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got 0x%04h flags %04b, required no output",
                   out_result, out_flags);
        end else begin
          e = sb_q[0];
          n_tests++;
          if (out_result !== e.res || out_flags !== e.flags) begin
            n_fail++;
            $display("FAIL %s id=%0d: got 0x%04h flags %04b, required 0x%04h flags %04b",
                     out_ready ? "result" : "stall_hold", e.id, out_result, out_flags,
                     e.res, e.flags);
          end
          if (out_ready) begin
            void'(sb_q.pop_front());
            if (e.chk_lat) begin
              n_tests++;
              if (cyc != e.due) begin
                n_fail++;
                $display("FAIL latency id=%0d: got cycle %0d, required cycle %0d",
                         e.id, cyc, e.due);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 60) begin
      @(negedge clock);
      i++;
    end
    chk(tag, sb_q.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000};
    vecs[1]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101};
    vecs[2]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000};
    vecs[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001};
    vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001};
    vecs[5]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000};
    vecs[6]  = '{16'h03FF, 16'h0001, 1'b0, 16'h0400, 4'b0000};
    vecs[7]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000};
    vecs[9]  = '{16'h3C00, 16'h0C00, 1'b1, 16'h3C00, 4'b0001};
    vecs[10] = '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000};
    vecs[11] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
    vecs[12] = '{16'h7C01, 16'h0000, 1'b0, 16'h7E00, 4'b1000};
    vecs[13] = '{16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 4'b0000};
    vecs[14] = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};
    vecs[15] = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0000};
    vecs[16] = '{16'hBC00, 16'h3C00, 1'b0, 16'h0000, 4'b0000};
    vecs[17] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 4'b0000};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_sub = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_flags", out_flags, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clock); #1;

    fork
      monitor();
    join_none

    // Directed vectors, back to back
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].flags, i);
    end
    drain("drain_directed");

    // Backpressure: stall the output for 4 cycles once it first goes valid
    chk_lat_mode = 1'b0;
    fork
      begin
        issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 100);
        issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000, 101);
        issue(16'h4200, 16'h3C00, 1'b0, 16'h4400, 4'b0000, 102);
        issue(16'h4400, 16'h3C00, 1'b0, 16'h4500, 4'b0000, 103);
        issue(16'h4500, 16'h3C00, 1'b0, 16'h4600, 4'b0000, 104);
      end
      begin : stall
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
          @(posedge clock); #1;
          k++;
        end
        chk("bp_valid_rise", out_valid, 1);
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clock);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold_valid", out_valid, 1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (5) begin
          @(negedge clock);
          chk("bp_drain_valid", out_valid, 1);
        end
      end
    join
    drain("drain_backpressure");
    chk_lat_mode = 1'b1;

    // Reset with two operations in flight: nothing may come out afterwards
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 200);
    issue(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000, 201);
    reset_n = 1'b0;
    sb_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_result", out_result, 0);
    chk("flush_out_flags", out_flags, 0);
    repeat (10) @(posedge clock);
    #1;
    issue(16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 202);
    drain("drain_after_reset");

    // Wide format instance: expect the result on the third negedge after acceptance
    for (int v = 0; v < 3; v++) begin
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] er;
      logic        es;
      int          lat;
      case (v)
        0:       begin ea = 32'h3F800000; eb = 32'h40000000; es = 1'b0; er = 32'h40400000; end
        1:       begin ea = 32'h40400000; eb = 32'h3F800000; es = 1'b1; er = 32'h40000000; end
        default: begin ea = 32'h3FC00000; eb = 32'h3FC00000; es = 1'b0; er = 32'h40400000; end
      endcase
      w_in_a = ea; w_in_b = eb; w_in_sub = es; w_in_valid = 1'b1;
      @(negedge clock);
      chk("fp32_in_ready", w_in_ready, 1);
      @(posedge clock); #1;
      w_in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        @(negedge clock);
        if (w_out_valid) lat = k;
      end
      chk("fp32_latency", lat, 3);
      chk("fp32_result", w_out_result, er);
      chk("fp32_flags", w_out_flags, 0);
      @(posedge clock); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
